// File: rtl/complex_alu.sv
// complex_alu: multi-cycle complex-number ALU feeding the operation controller.
//
// Ports:
//   clock     rising-edge clock
//   reset     synchronous, active-low reset
//   start     request, sampled only while idle
//   opr       4-bit opcode (controller opr map)
//   a_in/b_in packed complex operands {real[2CW-1:CW], imag[CW-1:0]}
//   out_alux  result {real[4CW-1:2CW], imag[2CW-1:0]}, held until next completion
//   done      one-cycle completion pulse, out_alux valid from this cycle
//   busy      operation in flight
//   err       illegal-opcode flag (only when ALU_ILLEGAL_OP_EN is defined)
//
// Optional feature macro: ALU_ILLEGAL_OP_EN. When defined, illegal opcodes are
// accepted and complete in one cycle with out_alux=0 and err=1. When undefined,
// illegal opcodes are ignored and the err port does not exist.
module complex_alu #(
    parameter int CW = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      opr,
    input  logic [2*CW-1:0] a_in,
    input  logic [2*CW-1:0] b_in,
    output logic [4*CW-1:0] out_alux,
    output logic            done,
    output logic            busy
`ifdef ALU_ILLEGAL_OP_EN
    ,
    output logic            err
`endif
);

    localparam logic [3:0] OP_PASS_A = 4'b0000;
    localparam logic [3:0] OP_PASS_B = 4'b0001;
    localparam logic [3:0] OP_SUM    = 4'b0010;
    localparam logic [3:0] OP_SUB    = 4'b0011;
    localparam logic [3:0] OP_CMUL   = 4'b0100;
    localparam logic [3:0] OP_RMUL   = 4'b0110;
    localparam logic [3:0] OP_EQ     = 4'b1000;
    localparam logic [3:0] OP_MOD_A  = 4'b1001;
    localparam logic [3:0] OP_MOD_B  = 4'b1010;

    localparam int CNTW = (CW > 4) ? $clog2(CW) : 2;
    localparam logic [CNTW-1:0] CNT_SQRT_LAST = CNTW'(CW - 1);

    typedef enum logic [2:0] {IDLE, EXEC, MUL, SQ, SQRT} state_t;

    function automatic logic legal_op(input logic [3:0] op);
        case (op)
            OP_PASS_A, OP_PASS_B, OP_SUM, OP_SUB, OP_CMUL,
            OP_RMUL, OP_EQ, OP_MOD_A, OP_MOD_B: legal_op = 1'b1;
            default:                            legal_op = 1'b0;
        endcase
    endfunction

    function automatic logic [2*CW-1:0] sx_cw(input logic [CW-1:0] v);
        sx_cw = {{CW{v[CW-1]}}, v};
    endfunction

    function automatic logic [2*CW-1:0] sx_cw1(input logic [CW:0] v);
        sx_cw1 = {{(CW-1){v[CW]}}, v};
    endfunction

    state_t                state;
    logic [CNTW-1:0]       cnt;
    logic [3:0]            op_q;
    logic [2*CW-1:0]       a_q, b_q;
    logic signed [2*CW-1:0] acc_r, acc_i;
    logic [CW+1:0]         rem;
    logic [CW-1:0]         root;

    logic                  accept;
    logic                  finish;
    logic [CNTW-1:0]       last_mul;

`ifdef ALU_ILLEGAL_OP_EN
    assign accept = start;
`else
    assign accept = start && legal_op(opr);
`endif

    // Operand component views
    logic signed [CW-1:0] a_r, a_i, b_r, b_i, src_r, src_i;
    logic [2*CW-1:0]      src_q;
    assign a_r   = a_q[2*CW-1:CW];
    assign a_i   = a_q[CW-1:0];
    assign b_r   = b_q[2*CW-1:CW];
    assign b_i   = b_q[CW-1:0];
    assign src_q = (op_q == OP_MOD_B) ? b_q : a_q;
    assign src_r = src_q[2*CW-1:CW];
    assign src_i = src_q[CW-1:0];

    // Single shared CWxCW signed multiplier; operands chosen by state/step
    logic signed [CW-1:0]   mul_x, mul_y;
    logic signed [2*CW-1:0] prod;
    always_comb begin
        mul_x = a_r;
        mul_y = b_r;
        if (state == SQ) begin
            mul_x = cnt[0] ? src_i : src_r;
            mul_y = cnt[0] ? src_i : src_r;
        end else begin
            case (cnt[1:0])
                2'd0:    begin mul_x = a_r; mul_y = b_r; end
                2'd1:    begin mul_x = a_i; mul_y = b_i; end
                2'd2:    begin mul_x = a_r; mul_y = b_i; end
                default: begin mul_x = a_i; mul_y = b_r; end
            endcase
        end
    end
    assign prod = mul_x * mul_y;

    // Single-cycle results, computed at CW+1 bits then sign-extended
    logic [CW:0]     sum_r, sum_i, sub_r, sub_i;
    logic [4*CW-1:0] exec_res;
    assign sum_r = {a_r[CW-1], a_r} + {b_r[CW-1], b_r};
    assign sum_i = {a_i[CW-1], a_i} + {b_i[CW-1], b_i};
    assign sub_r = {a_r[CW-1], a_r} - {b_r[CW-1], b_r};
    assign sub_i = {a_i[CW-1], a_i} - {b_i[CW-1], b_i};

    always_comb begin
        exec_res = '0;
        case (op_q)
            OP_PASS_A: exec_res = {sx_cw(a_r), sx_cw(a_i)};
            OP_PASS_B: exec_res = {sx_cw(b_r), sx_cw(b_i)};
            OP_SUM:    exec_res = {sx_cw1(sum_r), sx_cw1(sum_i)};
            OP_SUB:    exec_res = {sx_cw1(sub_r), sx_cw1(sub_i)};
            OP_EQ:     exec_res = {{(4*CW-1){1'b0}}, (a_q == b_q)};
            default:   exec_res = '0;  // illegal opcodes complete with zero
        endcase
    end

    // Restoring square root step: acc_r holds the radicand, consumed two bits
    // at a time from the top; one root bit produced per cycle, MSB first.
    logic [CW+1:0] rem_sh, trial, rem_nx;
    logic          sq_ge;
    logic [CW-1:0] root_nx;
    assign rem_sh  = (rem << 2) | {{CW{1'b0}}, acc_r[2*CW-1:2*CW-2]};
    assign trial   = {root, 2'b01};
    assign sq_ge   = (rem_sh >= trial);
    assign rem_nx  = sq_ge ? (rem_sh - trial) : rem_sh;
    assign root_nx = {root[CW-2:0], sq_ge};

    assign last_mul = (op_q == OP_RMUL) ? CNTW'(1) : CNTW'(3);
    assign finish   = (state == EXEC) ||
                      ((state == MUL)  && (cnt == last_mul)) ||
                      ((state == SQRT) && (cnt == CNT_SQRT_LAST));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_r    <= '0;
            acc_i    <= '0;
            rem      <= '0;
            root     <= '0;
            out_alux <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                busy  <= 1'b0;
                state <= IDLE;
            end
            case (state)
                IDLE: if (accept) begin
                    op_q <= opr;
                    a_q  <= a_in;
                    b_q  <= b_in;
                    busy <= 1'b1;
                    cnt  <= '0;
                    case (opr)
                        OP_CMUL, OP_RMUL:   state <= MUL;
                        OP_MOD_A, OP_MOD_B: state <= SQ;
                        default:            state <= EXEC;
                    endcase
                end
                EXEC: out_alux <= exec_res;
                MUL: begin
                    cnt <= cnt + 1'b1;
                    case (cnt[1:0])
                        2'd0: acc_r <= prod;
                        2'd1: begin
                            if (op_q == OP_RMUL) out_alux <= {acc_r, prod};
                            else                 acc_r    <= acc_r - prod;
                        end
                        2'd2:    acc_i    <= prod;
                        default: out_alux <= {acc_r, acc_i + prod};
                    endcase
                end
                SQ: begin
                    if (!cnt[0]) begin
                        acc_r <= prod;
                        cnt   <= cnt + 1'b1;
                    end else begin
                        // Sum of squares fits unsigned 2*CW bits
                        acc_r <= acc_r + prod;
                        cnt   <= '0;
                        rem   <= '0;
                        root  <= '0;
                        state <= SQRT;
                    end
                end
                SQRT: begin
                    acc_r <= acc_r << 2;
                    rem   <= rem_nx;
                    root  <= root_nx;
                    cnt   <= cnt + 1'b1;
                    if (finish) out_alux <= {{CW{1'b0}}, root_nx, {(2*CW){1'b0}}};
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ILLEGAL_OP_EN
    // err reflects the most recent completion; every completion rewrites it
    always_ff @(posedge clock) begin
        if (!reset)      err <= 1'b0;
        else if (finish) err <= !legal_op(op_q);
    end
`endif

endmodule

// File: doc/complex_alu.md
Name: complex_alu

Overview:
- Multi-cycle complex-number ALU; sits directly upstream of the operation controller.
- Accepts an opcode plus two packed complex operands on a start pulse and computes the result over a fixed number of cycles.
- Presents the result on out_alux with a one-cycle done pulse.
- Opcode encoding matches the controller's opr map.

Parameters:
- CW, 16: signed width of each operand component. Operand width is 2*CW; result width is 4*CW; each result component is 2*CW.

Ports:
- clock  in  1  master clock, rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- opr  in  4  opcode
- a_in  in  2*CW  operand A: real [2CW-1:CW], imag [CW-1:0], two's complement
- b_in  in  2*CW  operand B, same packing as A
- out_alux  out  4*CW  result: real [4CW-1:2CW], imag [2CW-1:0], two's complement
- done  out  1  one-cycle pulse; out_alux valid from this cycle
- busy  out  1  high while an operation is in flight
- err  out  1  illegal-opcode flag; present only with the macro

Behaviour:
- Reset: reset==0 at a rising edge forces state IDLE, out_alux=0, done=0, busy=0, err=0, step counter=0. This applies from any state; a mid-operation abort produces no done.
- Accept: in IDLE with start==1 and a legal opr, latch opr/a_in/b_in, set busy=1. start is ignored while busy.
- Latency L: done rises L cycles after the accepting edge.
  - out_alux is written on the same edge that raises done.
  - done lasts exactly 1 cycle; out_alux holds until the next completion.
  - busy falls on that same edge and the FSM returns to IDLE, so start may be accepted while done==1 (back-to-back, no bubble).
- Opcodes (component results sign-extended to 2*CW):
  - 0000 pass A, L=1
  - 0001 pass B, L=1
  - 0010 sum: (ar+br, ai+bi), L=1
  - 0011 sub: (ar-br, ai-bi), L=1
  - 0100 complex mult: (ar*br-ai*bi, ar*bi+ai*br), L=4. Exactly one CWxCW signed product per cycle through a single shared multiplier, accumulated at 2*CW; no overflow is possible at 2*CW.
  - 0110 real mult: (ar*br, ai*bi), L=2, one product per cycle
  - 1000 equality: out_alux=1 if A==B (all 2*CW bits) else 0, L=1
  - 1001 mod A: real = floor(sqrt(ar^2+ai^2)), imag = 0, L=2+CW
  - 1010 mod B: as mod A on B
- Modulus pipeline:
  - Cycle 1: square real part. Cycle 2: add square of imag part into an unsigned 2*CW accumulator; max 2^(2CW-1), no overflow.
  - Then CW cycles of restoring digit-by-digit square root, one result bit per cycle, MSB first.
- FSM states: IDLE, EXEC (1-cycle ops), MUL (counter 0..3 or 0..1), SQ (counter 0..1), SQRT (counter 0..CW-1), DONE transition folded into the final step edge.
- Illegal opcodes (0101, 0111, 1011-1111): see Optional Feature.

Optional Feature:
- Macro: ALU_ILLEGAL_OP_EN.
- Defined:
  - err port exists.
  - Illegal opr with start in IDLE is accepted, L=1.
  - out_alux is set to 0 and err=1, both on the done edge.
  - err holds until the next completion, which clears it. Reset clears err.
- Not defined:
  - No err port.
  - Illegal opr is ignored: stays IDLE, busy=0, no done, out_alux unchanged.

Test Plan:
- Sum, opr=0010, A=(3,-4), B=(5,7) -> 1 cycle later done=1, out_alux=0x00000008_00000003; next cycle done=0, value held.
- Complex mult, opr=0100, A=(1,2), B=(3,4) -> done exactly 4 cycles after accept, out_alux=0xFFFFFFFB_0000000A; start pulses at cycles 1-3 ignored.
- Modulus:
  - opr=1001, A=(3,4) -> done after 18 cycles, out=0x00000005_00000000.
  - A=(-32768,-32768) -> real=46340.
  - opr=1010, B=(0,0) -> 0.
- Back-to-back: start held high with opr=0000, A=(7,9), then opr=1000, A==B -> dones at consecutive accepts with no idle cycle; results A then 1.
- Reset mid-op: opr=1001, reset=0 at cycle 5 -> next cycle busy=0, done=0, out_alux=0; no done ever appears for that op.
- Illegal opcode 0101:
  - With ALU_ILLEGAL_OP_EN -> done after 1 cycle, out_alux=0, err=1; a following legal op clears err.
  - Without the macro -> busy never rises, no done.
